// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU constants: ROB/result widths, the reserved "no tag" value and the
// reservation-station tag encoding used by the functional units.
package cdb_arbiter_pkg;

    // Reorder-buffer tag width and result data width
    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    // Tags at or above this value never name a live ROB entry; idle CDB lanes
    // carry it so that consumers never match it by accident.
    localparam int INVALID_TAG = 16;

    // Reservation-station identification shared with the issue logic
    localparam int RS_NUM   = 4;
    localparam int RS_TAG_W = 2;

    typedef enum logic [RS_TAG_W-1:0] {
        RS_ALU0 = 2'd0,
        RS_ALU1 = 2'd1,
        RS_MUL  = 2'd2,
        RS_LSU  = 2'd3
    } rs_tag_e;

endpackage : cdb_arbiter_pkg

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result bus into the arbiter plus the two CDB broadcast lanes.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ROB_W   = cdb_arbiter_pkg::ROB_W,
    parameter int DATA_W  = cdb_arbiter_pkg::DATA_W
);

    // Requester side: slice i of each vector belongs to requester i
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ROB_W-1:0]  req_robNum;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    // CDB lane 0
    logic                      CDBiscast;
    logic [ROB_W-1:0]          CDBrobNum;
    logic [DATA_W-1:0]         CDBdata;

    // CDB lane 1
    logic                      CDBiscast2;
    logic [ROB_W-1:0]          CDBrobNum2;
    logic [DATA_W-1:0]         CDBdata2;

    // At least one result still queued
    logic                      busy;

    // Functional units and CDB consumers
    modport master (
        output req_valid, req_robNum, req_data,
        input  req_ready,
        input  CDBiscast, CDBrobNum, CDBdata,
        input  CDBiscast2, CDBrobNum2, CDBdata2,
        input  busy
    );

    // The arbiter itself
    modport slave (
        input  req_valid, req_robNum, req_data,
        output req_ready,
        output CDBiscast, CDBrobNum, CDBdata,
        output CDBiscast2, CDBrobNum2, CDBdata2,
        output busy
    );

endinterface : cdb_arbiter_if

// File: rtl/cdb_req_fifo.sv
// Two-entry result buffer for one functional unit. Results carrying a tag at or
// above INVALID_TAG are handshaken normally but silently discarded.
module cdb_req_fifo #(
    parameter int ROB_W  = cdb_arbiter_pkg::ROB_W,
    parameter int DATA_W = cdb_arbiter_pkg::DATA_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [ROB_W-1:0]  push_rob_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              ready_o,
    output logic              not_empty_o,
    output logic              not_empty_d_o,
    output logic [ROB_W-1:0]  head_rob_o,
    output logic [DATA_W-1:0] head_data_o
);
    import cdb_arbiter_pkg::*;

    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       tag_ok;
    logic       do_push;
    logic       do_pop;
    logic       wr_en;
    logic       wr_idx;

    // Space is judged on the pre-edge count, so a full buffer refuses a push
    // even while its head is being popped.
    assign ready_o     = (count_q != 2'd2);
    assign not_empty_o = (count_q != 2'd0);
    assign head_rob_o  = mem_q[rd_ptr_q].rob;
    assign head_data_o = mem_q[rd_ptr_q].data;

    // Next-state for occupancy and read pointer; flush empties the buffer
    always_comb begin
        // NOTE: every signal written here gets a value on every path first, otherwise a latch is inferred.
        tag_ok   = (int'(push_rob_i) < INVALID_TAG);
        do_push  = push_i && ready_o && tag_ok;
        do_pop   = pop_i && not_empty_o;
        wr_idx   = rd_ptr_q ^ count_q[0];
        wr_en    = do_push && !flush_i;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        rd_ptr_d = rd_ptr_q ^ do_pop;
        if (flush_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
        end
        not_empty_d_o = (count_d != 2'd0);
    end

    // Occupancy and read-pointer registers
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage
    always_ff @(posedge clock_i) begin
        // NOTE: storage is not reset; an entry is only read while the count says it is valid.
        if (wr_en) begin
            mem_q[wr_idx] <= '{rob: push_rob_i, data: push_data_i};
        end
    end

endmodule : cdb_req_fifo

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit two-entry buffers feeding two registered
// broadcast lanes, granted round-robin starting at ptr_q.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ROB_W   = cdb_arbiter_pkg::ROB_W,
    parameter int DATA_W  = cdb_arbiter_pkg::DATA_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    import cdb_arbiter_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic              iscast;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] data;
    } lane_t;

    localparam lane_t LANE_IDLE = '{iscast: 1'b0, rob: ROB_W'(INVALID_TAG), data: '0};

    logic [NUM_REQ-1:0] ready_w;
    logic [NUM_REQ-1:0] not_empty;
    logic [NUM_REQ-1:0] not_empty_d;
    logic [NUM_REQ-1:0] pop;
    logic [ROB_W-1:0]   head_rob  [NUM_REQ];
    logic [DATA_W-1:0]  head_data [NUM_REQ];

    logic               grant0_vld, grant1_vld;
    logic [IDX_W-1:0]   grant0_idx, grant1_idx;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    lane_t              lane0_q, lane0_d;
    lane_t              lane1_q, lane1_d;
    logic               busy_q, busy_d;

    // (base + off) mod NUM_REQ for base < NUM_REQ and 0 <= off < NUM_REQ
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        cdb_req_fifo #(
            .ROB_W  (ROB_W),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clock_i       (clock),
            .reset_i       (reset),
            .flush_i       (flush),
            .push_i        (bus.req_valid[g]),
            .push_rob_i    (bus.req_robNum[g*ROB_W +: ROB_W]),
            .push_data_i   (bus.req_data[g*DATA_W +: DATA_W]),
            .pop_i         (pop[g]),
            .ready_o       (ready_w[g]),
            .not_empty_o   (not_empty[g]),
            .not_empty_d_o (not_empty_d[g]),
            .head_rob_o    (head_rob[g]),
            .head_data_o   (head_data[g])
        );
    end

    // Round-robin pick: lane 0 is the first non-empty buffer at or after
    // ptr_q, lane 1 the next non-empty buffer after lane 0's pick.
    always_comb begin
        grant0_vld = 1'b0;
        grant0_idx = '0;
        grant1_vld = 1'b0;
        grant1_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant0_vld && not_empty[wrap_idx(ptr_q, i)]) begin
                grant0_vld = 1'b1;
                grant0_idx = wrap_idx(ptr_q, i);
            end
        end
        for (int i = 1; i < NUM_REQ; i++) begin
            if (grant0_vld && !grant1_vld && not_empty[wrap_idx(grant0_idx, i)]) begin
                grant1_vld = 1'b1;
                grant1_idx = wrap_idx(grant0_idx, i);
            end
        end
        pop = '0;
        if (grant0_vld) begin
            pop[grant0_idx] = 1'b1;
        end
        if (grant1_vld) begin
            pop[grant1_idx] = 1'b1;
        end
    end

    // Next broadcast, pointer and busy; flush idles both lanes and rewinds ptr
    always_comb begin
        lane0_d = LANE_IDLE;
        lane1_d = LANE_IDLE;
        ptr_d   = ptr_q;
        busy_d  = |not_empty_d;
        if (flush) begin
            ptr_d  = '0;
            busy_d = 1'b0;
        end else begin
            if (grant0_vld) begin
                lane0_d = '{iscast: 1'b1, rob: head_rob[grant0_idx], data: head_data[grant0_idx]};
                ptr_d   = wrap_idx(grant0_idx, 1);
            end
            if (grant1_vld) begin
                lane1_d = '{iscast: 1'b1, rob: head_rob[grant1_idx], data: head_data[grant1_idx]};
                ptr_d   = wrap_idx(grant1_idx, 1);
            end
        end
    end

    // Registered CDB lanes, round-robin pointer and busy flag
    always_ff @(posedge clock) begin
        if (reset) begin
            lane0_q <= LANE_IDLE;
            lane1_q <= LANE_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.req_ready  = ready_w;
    assign bus.CDBiscast  = lane0_q.iscast;
    assign bus.CDBrobNum  = lane0_q.rob;
    assign bus.CDBdata    = lane0_q.data;
    assign bus.CDBiscast2 = lane1_q.iscast;
    assign bus.CDBrobNum2 = lane1_q.rob;
    assign bus.CDBdata2   = lane1_q.data;
    assign bus.busy       = busy_q;

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed lane contents, pointer,
// ready and busy after each edge.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ROB_W   = 6;
    localparam int DATA_W  = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    int errors = 0;
    int checks = 0;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid  = '0;
        bus.req_robNum = '0;
        bus.req_data   = '0;
        flush          = 1'b0;
    endtask

    task automatic drive(input int i, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] data);
        bus.req_valid[i]                = 1'b1;
        bus.req_robNum[i*ROB_W +: ROB_W]  = tag;
        bus.req_data[i*DATA_W +: DATA_W]  = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_lane0(input string tag, input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] data);
        check({tag, ".cast0"}, bus.CDBiscast, 1'b1);
        check({tag, ".rob0"},  bus.CDBrobNum, rob);
        check({tag, ".data0"}, bus.CDBdata,   data);
    endtask

    task automatic check_lane1(input string tag, input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] data);
        check({tag, ".cast1"}, bus.CDBiscast2, 1'b1);
        check({tag, ".rob1"},  bus.CDBrobNum2, rob);
        check({tag, ".data1"}, bus.CDBdata2,   data);
    endtask

    task automatic check_idle0(input string tag);
        check({tag, ".idle_cast0"}, bus.CDBiscast, 1'b0);
        check({tag, ".idle_rob0"},  bus.CDBrobNum, 6'd16);
        check({tag, ".idle_data0"}, bus.CDBdata,   32'd0);
    endtask

    task automatic check_idle1(input string tag);
        check({tag, ".idle_cast1"}, bus.CDBiscast2, 1'b0);
        check({tag, ".idle_rob1"},  bus.CDBrobNum2, 6'd16);
        check({tag, ".idle_data1"}, bus.CDBdata2,   32'd0);
    endtask

    initial begin
        idle_inputs();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check_idle0("rst");
        check_idle1("rst");
        check("rst.busy",  bus.busy, 1'b0);
        check("rst.ready", bus.req_ready, 4'hF);
        check("rst.ptr",   dut.ptr_q, 2'd0);
        reset = 1'b0;

        // Single push: req0 tag 3 data 0x11, one-cycle latency, lane 1 idle
        drive(0, 6'd3, 32'h11);
        tick();
        check("single.latency", bus.CDBiscast, 1'b0);
        check("single.busy_n",  bus.busy, 1'b1);
        idle_inputs();
        tick();
        check_lane0("single", 6'd3, 32'h11);
        check_idle1("single");
        check("single.busy", bus.busy, 1'b0);
        check("single.ptr",  dut.ptr_q, 2'd1);
        tick();
        check_idle0("single.after");

        // Pointer at 1: req0 and req3 pending -> lane0 req3, lane1 wraps to req0
        drive(0, 6'd7, 32'h77);
        drive(3, 6'd8, 32'h88);
        tick();
        idle_inputs();
        tick();
        check_lane0("wrap", 6'd8, 32'h88);
        check_lane1("wrap", 6'd7, 32'h77);
        check("wrap.ptr", dut.ptr_q, 2'd1);

        // All four push together from ptr=0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            drive(i, 6'(i + 1), 32'hA1 + 32'(i));
        end
        tick();
        idle_inputs();
        tick();
        check_lane0("all4.e1", 6'd1, 32'hA1);
        check_lane1("all4.e1", 6'd2, 32'hA2);
        check("all4.e1.ptr",  dut.ptr_q, 2'd2);
        check("all4.e1.busy", bus.busy, 1'b1);
        tick();
        check_lane0("all4.e2", 6'd3, 32'hA3);
        check_lane1("all4.e2", 6'd4, 32'hA4);
        check("all4.e2.ptr",  dut.ptr_q, 2'd0);
        check("all4.e2.busy", bus.busy, 1'b0);
        tick();
        check_idle0("all4.e3");
        check_idle1("all4.e3");

        // req2 fills while req0/req1 hold both lanes; third push refused
        do_reset();
        drive(0, 6'd1, 32'h101);
        drive(1, 6'd2, 32'h102);
        drive(2, 6'd10, 32'h10A);
        tick();
        check("full.e1.ready", bus.req_ready, 4'hF);
        idle_inputs();
        drive(0, 6'd3, 32'h103);
        drive(1, 6'd4, 32'h104);
        drive(2, 6'd11, 32'h10B);
        tick();
        check("full.e2.ready", bus.req_ready, 4'b1011);
        check_lane0("full.e2", 6'd1, 32'h101);
        check_lane1("full.e2", 6'd2, 32'h102);
        idle_inputs();
        drive(2, 6'd12, 32'h10C);
        tick();
        check_lane0("full.e3", 6'd10, 32'h10A);
        check_lane1("full.e3", 6'd3, 32'h103);
        check("full.e3.ready", bus.req_ready, 4'hF);
        idle_inputs();
        tick();
        check_lane0("full.e4", 6'd4, 32'h104);
        check_lane1("full.e4", 6'd11, 32'h10B);
        check("full.e4.busy", bus.busy, 1'b0);
        tick();
        check_idle0("full.e5");
        check_idle1("full.e5");

        // Flush with two pending and a same-edge push of tag 5
        do_reset();
        drive(1, 6'd1, 32'h201);
        drive(2, 6'd2, 32'h202);
        tick();
        check("flush.pre.busy", bus.busy, 1'b1);
        idle_inputs();
        drive(3, 6'd5, 32'h205);
        flush = 1'b1;
        tick();
        idle_inputs();
        check_idle0("flush.e1");
        check_idle1("flush.e1");
        check("flush.busy", bus.busy, 1'b0);
        check("flush.ptr",  dut.ptr_q, 2'd0);
        tick();
        check_idle0("flush.e2");
        check_idle1("flush.e2");
        check("flush.e2.busy", bus.busy, 1'b0);

        // Invalid tags are dropped at push
        do_reset();
        drive(1, 6'd16, 32'hDEAD);
        drive(2, 6'd63, 32'hBEEF);
        tick();
        check("inv.busy",  bus.busy, 1'b0);
        check("inv.ready", bus.req_ready, 4'hF);
        idle_inputs();
        tick();
        check_idle0("inv.e2");
        check_idle1("inv.e2");
        check("inv.e2.busy", bus.busy, 1'b0);

        // Reset while three buffers hold data, with a push on the same edge
        do_reset();
        drive(0, 6'd1, 32'h301);
        drive(1, 6'd2, 32'h302);
        drive(3, 6'd3, 32'h303);
        tick();
        check("mid.pre.busy", bus.busy, 1'b1);
        idle_inputs();
        drive(2, 6'd9, 32'h309);
        reset = 1'b1;
        tick();
        check_idle0("mid.rst");
        check_idle1("mid.rst");
        check("mid.busy",  bus.busy, 1'b0);
        check("mid.ready", bus.req_ready, 4'hF);
        reset = 1'b0;
        idle_inputs();
        tick();
        check_idle0("mid.after");
        check_idle1("mid.after");
        check("mid.after.busy", bus.busy, 1'b0);
        tick();
        check_idle0("mid.after2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cdb_arbiter

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit requesters sharing the CDB.
REQ-002 Parameter ROB_W, default 6, ROB tag width.
REQ-003 Parameter DATA_W, default 32, result data width.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous squash (mispredict); discards all pending results.
REQ-007 req_valid  input  NUM_REQ  per-requester result valid.
REQ-008 req_robNum  input  NUM_REQ*ROB_W  per-requester destination ROB tag; slice i belongs to requester i.
REQ-009 req_data  input  NUM_REQ*DATA_W  per-requester result value.
REQ-010 req_ready  output  NUM_REQ  per-requester buffer has space.
REQ-011 CDBiscast, CDBrobNum, CDBdata  output  1/ROB_W/DATA_W  CDB lane 0.
REQ-012 CDBiscast2, CDBrobNum2, CDBdata2  output  1/ROB_W/DATA_W  CDB lane 1.
REQ-013 busy  output  1  at least one result is pending.

Function
REQ-014 Each requester SHALL own a 2-entry FIFO; a push occurs on a rising edge when req_valid[i] and req_ready[i] are both high.
REQ-015 req_ready[i] SHALL equal "FIFO i count < 2", based on state before the edge; a full FIFO never accepts a push, even when it is popped in the same cycle.
REQ-016 Simultaneous push and pop on a FIFO SHALL leave its count unchanged and preserve FIFO order.
REQ-017 Each edge, the arbiter SHALL grant up to two distinct non-empty FIFOs, using heads as they were before the edge.
REQ-018 Lane 0 SHALL take the first non-empty FIFO at or after the round-robin pointer ptr, searching modulo NUM_REQ.
REQ-019 Lane 1 SHALL take the next non-empty FIFO after the lane-0 grant; no requester receives both lanes in one cycle.
REQ-020 Granted heads SHALL be popped on that same edge.
REQ-021 CDB outputs SHALL be registered; a result pushed at edge N is broadcast no earlier than edge N+1 (minimum latency 1 cycle).
REQ-022 After any grant, ptr SHALL become (index of last granted requester + 1) mod NUM_REQ; with no grant, ptr is unchanged.
REQ-023 An idle lane SHALL drive iscast=0, robNum=INVALID_TAG (6'd16), data=0.
REQ-024 A single pending requester SHALL use lane 0 only; lane 1 stays idle.
REQ-025 A pushed entry with robNum >= INVALID_TAG SHALL be dropped at push and never broadcast.
REQ-026 On flush, the arbiter SHALL empty all FIFOs, set both lanes idle on that edge, and set ptr=0.
REQ-027 Flush SHALL take priority over a same-cycle push and over grants.
REQ-028 busy SHALL be the registered OR of all FIFO counts being non-zero, reflecting post-edge state.

Reset
REQ-029 On reset high at an edge: all FIFOs empty, ptr=0, both lanes idle per REQ-023, busy=0, req_ready all 1 from the next cycle.
REQ-030 Reset SHALL override flush, push and grant, and SHALL abort in-flight results mid-operation with no partial broadcast afterwards.

Structure
REQ-031 ROB_W, DATA_W and INVALID_TAG SHALL live in the shared CPU package, alongside the reservation stations' tag constants.
REQ-032 The per-requester 2-entry buffer SHALL be one sub-module, cdb_req_fifo, instantiated NUM_REQ times.

Verification
REQ-033 Single push, req0 tag 3 data 0x11 at edge N -> CDBiscast=1, CDBrobNum=3, CDBdata=0x11 after edge N+1; lane 1 idle.
REQ-034 All four requesters push together (tags 1..4), ptr=0 -> edge N+1: lanes carry tags 1 and 2, ptr=2; edge N+2: lanes carry tags 3 and 4, ptr=0.
REQ-035 req2 pushes on three consecutive edges with no grants possible -> req_ready[2]=0 after two pushes; third value not accepted and never broadcast.
REQ-036 Two entries pending plus a push of tag 5 with flush high on the same edge -> nothing broadcast afterwards, busy=0, ptr=0.
REQ-037 Push with tag 16 -> no broadcast ever; busy stays 0.
REQ-038 Assert reset while three FIFOs hold data -> after the edge, lanes idle with robNum=16, busy=0, all req_ready=1.
